// File: rtl/pipe_hazard_ctrl.sv
// Hazard control for a five-stage MIPS-style pipeline: freeze, redirect flush,
// load-use bubble, registered EX forwarding selects and saturating event counters.
module pipe_hazard_ctrl (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [4:0]  ID_Rs,
    input  logic [4:0]  ID_Rt,
    input  logic        ID_UsesRt,
    input  logic [4:0]  EX_Rw,
    input  logic        EX_RegWr,
    input  logic        EX_MemtoReg,
    input  logic [4:0]  MEM_Rw,
    input  logic        MEM_RegWr,
    input  logic        MEM_Branch,
    input  logic        MEM_Zero,
    input  logic        MEM_Jump,
    input  logic        Ext_Stall,
    output logic        Pipe_En,
    output logic        PC_Write,
    output logic        IFID_Write,
    output logic        IDEX_Bubble,
    output logic        Flush_IFID,
    output logic        Flush_IDEX,
    output logic        Flush_EXMEM,
    output logic [1:0]  PC_Sel,
    output logic [1:0]  FwdA,
    output logic [1:0]  FwdB,
    output logic [15:0] Stall_Cnt,
    output logic [15:0] Flush_Cnt
);

    typedef enum logic [1:0] {
        FWD_REG   = 2'b00,
        FWD_EXMEM = 2'b01,
        FWD_MEMWB = 2'b10
    } fwd_sel_e;

    localparam logic [1:0] SEL_PC4  = 2'b00;
    localparam logic [1:0] SEL_BTGT = 2'b01;
    localparam logic [1:0] SEL_JTGT = 2'b10;
    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    logic     taken_branch;
    logic     redirect;
    logic     load_use;
    logic     stall_now;
    logic     flush_now;
    logic     ex_fwd_ok;
    logic     mem_fwd_ok;
    fwd_sel_e fwd_a_next;
    fwd_sel_e fwd_b_next;

    // Ext_Stall dominates redirect, and redirect dominates the load-use stall.
    always_comb begin
        taken_branch = MEM_Branch & MEM_Zero;
        redirect     = taken_branch | MEM_Jump;
        load_use     = EX_MemtoReg & EX_RegWr & (EX_Rw != 5'd0) &
                       ((EX_Rw == ID_Rs) | (ID_UsesRt & (EX_Rw == ID_Rt)));
        flush_now    = ~Ext_Stall & redirect;
        stall_now    = ~Ext_Stall & ~redirect & load_use;

        Pipe_En      = ~Ext_Stall;
        PC_Write     = ~Ext_Stall & ~stall_now;
        IFID_Write   = ~Ext_Stall & ~stall_now;
        IDEX_Bubble  = stall_now;
        Flush_IFID   = flush_now;
        Flush_IDEX   = flush_now;
        Flush_EXMEM  = flush_now;

        PC_Sel = SEL_PC4;
        if (!Ext_Stall) begin
            if (MEM_Jump)
                PC_Sel = SEL_JTGT;
            else if (taken_branch)
                PC_Sel = SEL_BTGT;
        end
    end

    // Register 0 is hardwired to zero, so it is never a forwarding source.
    always_comb begin
        ex_fwd_ok  = EX_RegWr & (EX_Rw != 5'd0);
        mem_fwd_ok = MEM_RegWr & (MEM_Rw != 5'd0);

        fwd_a_next = FWD_REG;
        if (ex_fwd_ok && EX_Rw == ID_Rs)
            fwd_a_next = FWD_EXMEM;
        else if (mem_fwd_ok && MEM_Rw == ID_Rs)
            fwd_a_next = FWD_MEMWB;

        fwd_b_next = FWD_REG;
        if (ID_UsesRt) begin
            if (ex_fwd_ok && EX_Rw == ID_Rt)
                fwd_b_next = FWD_EXMEM;
            else if (mem_fwd_ok && MEM_Rw == ID_Rt)
                fwd_b_next = FWD_MEMWB;
        end
    end

    // Selects travel with the ID instruction into EX; bubbles and flushes carry no operands.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            FwdA      <= FWD_REG;
            FwdB      <= FWD_REG;
            Stall_Cnt <= 16'd0;
            Flush_Cnt <= 16'd0;
        end else if (!Ext_Stall) begin
            if (stall_now || flush_now) begin
                FwdA <= FWD_REG;
                FwdB <= FWD_REG;
            end else begin
                FwdA <= fwd_a_next;
                FwdB <= fwd_b_next;
            end
            if (stall_now && Stall_Cnt != CNT_MAX)
                Stall_Cnt <= Stall_Cnt + 16'd1;
            if (flush_now && Flush_Cnt != CNT_MAX)
                Flush_Cnt <= Flush_Cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized bench for pipe_hazard_ctrl against a priority-rule reference model,
// plus directed hazard, redirect, freeze and counter-saturation scenarios.
module tb_pipe_hazard_ctrl;

    typedef struct packed {
        logic       reset;
        logic [4:0] id_rs;
        logic [4:0] id_rt;
        logic       id_uses_rt;
        logic [4:0] ex_rw;
        logic       ex_regwr;
        logic       ex_memtoreg;
        logic [4:0] mem_rw;
        logic       mem_regwr;
        logic       mem_branch;
        logic       mem_zero;
        logic       mem_jump;
        logic       ext_stall;
    } stim_t;

    logic        clk = 1'b0;
    logic        reset, id_uses_rt, ex_regwr, ex_memtoreg, mem_regwr;
    logic        mem_branch, mem_zero, mem_jump, ext_stall;
    logic [4:0]  id_rs, id_rt, ex_rw, mem_rw;
    logic        pipe_en, pc_write, ifid_write, idex_bubble;
    logic        flush_ifid, flush_idex, flush_exmem;
    logic [1:0]  pc_sel, fwd_a, fwd_b;
    logic [15:0] stall_cnt, flush_cnt;

    stim_t       s;
    int          check_count = 0;
    int          pass_count  = 0;
    logic [1:0]  m_fwd_a = 2'b00;
    logic [1:0]  m_fwd_b = 2'b00;
    int          m_stall = 0;
    int          m_flush = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl dut (
        .Clk(clk), .Reset(reset),
        .ID_Rs(id_rs), .ID_Rt(id_rt), .ID_UsesRt(id_uses_rt),
        .EX_Rw(ex_rw), .EX_RegWr(ex_regwr), .EX_MemtoReg(ex_memtoreg),
        .MEM_Rw(mem_rw), .MEM_RegWr(mem_regwr),
        .MEM_Branch(mem_branch), .MEM_Zero(mem_zero), .MEM_Jump(mem_jump),
        .Ext_Stall(ext_stall),
        .Pipe_En(pipe_en), .PC_Write(pc_write), .IFID_Write(ifid_write),
        .IDEX_Bubble(idex_bubble),
        .Flush_IFID(flush_ifid), .Flush_IDEX(flush_idex), .Flush_EXMEM(flush_exmem),
        .PC_Sel(pc_sel), .FwdA(fwd_a), .FwdB(fwd_b),
        .Stall_Cnt(stall_cnt), .Flush_Cnt(flush_cnt)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        check_count++;
        if (observed === expected)
            pass_count++;
        else
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    endtask

    function automatic logic [1:0] model_fwd(input stim_t st, input logic [4:0] src, input logic used);
        if (!used) return 2'b00;
        if (st.ex_regwr && st.ex_rw != 0 && st.ex_rw == src) return 2'b01;
        if (st.mem_regwr && st.mem_rw != 0 && st.mem_rw == src) return 2'b10;
        return 2'b00;
    endfunction

    // Applies s at the falling edge, checks against the model, then advances the model.
    task automatic applyStimulus(input bit do_check);
        logic       redirect, load_use, bubble, flush;
        logic [8:0] exp_ctrl;
        logic [1:0] exp_sel;
        @(negedge clk);
        reset = s.reset; id_rs = s.id_rs; id_rt = s.id_rt; id_uses_rt = s.id_uses_rt;
        ex_rw = s.ex_rw; ex_regwr = s.ex_regwr; ex_memtoreg = s.ex_memtoreg;
        mem_rw = s.mem_rw; mem_regwr = s.mem_regwr; mem_branch = s.mem_branch;
        mem_zero = s.mem_zero; mem_jump = s.mem_jump; ext_stall = s.ext_stall;
        #1;
        redirect = (s.mem_branch && s.mem_zero) || s.mem_jump;
        load_use = s.ex_memtoreg && s.ex_regwr && s.ex_rw != 0 &&
                   (s.ex_rw == s.id_rs || (s.id_uses_rt && s.ex_rw == s.id_rt));
        bubble = 1'b0;
        flush  = 1'b0;
        exp_sel = 2'b00;
        if (s.ext_stall) begin
            exp_ctrl = 9'b0;
        end else if (redirect) begin
            flush = 1'b1;
            exp_sel = s.mem_jump ? 2'b10 : 2'b01;
            exp_ctrl = {1'b1, 1'b1, 1'b1, 1'b0, 3'b111, exp_sel};
        end else if (load_use) begin
            bubble = 1'b1;
            exp_ctrl = {1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 2'b00};
        end else begin
            exp_ctrl = {1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 2'b00};
        end
        if (do_check) begin
            checkOutput("ctrl", {23'd0, pipe_en, pc_write, ifid_write, idex_bubble,
                                 flush_ifid, flush_idex, flush_exmem, pc_sel}, {23'd0, exp_ctrl});
            checkOutput("fwd", {28'd0, fwd_a, fwd_b}, {28'd0, m_fwd_a, m_fwd_b});
            checkOutput("stall_cnt", {16'd0, stall_cnt}, m_stall);
            checkOutput("flush_cnt", {16'd0, flush_cnt}, m_flush);
        end
        if (s.reset) begin
            m_fwd_a = 2'b00; m_fwd_b = 2'b00; m_stall = 0; m_flush = 0;
        end else if (!s.ext_stall) begin
            m_fwd_a = (bubble || flush) ? 2'b00 : model_fwd(s, s.id_rs, 1'b1);
            m_fwd_b = (bubble || flush) ? 2'b00 : model_fwd(s, s.id_rt, s.id_uses_rt);
            if (bubble) m_stall = (m_stall + 1 > 65535) ? 65535 : m_stall + 1;
            if (flush)  m_flush = (m_flush + 1 > 65535) ? 65535 : m_flush + 1;
        end
    endtask

    task automatic do_reset();
        s = '0;
        s.reset = 1'b1;
        applyStimulus(1'b1);
        s.reset = 1'b0;
    endtask

    initial begin
        s = '0;
        do_reset();

        // Load $5 in EX, add $6,$5,$7 in ID
        s.ex_rw = 5'd5; s.ex_regwr = 1'b1; s.ex_memtoreg = 1'b1;
        s.id_rs = 5'd5; s.id_rt = 5'd7; s.id_uses_rt = 1'b1;
        applyStimulus(1'b1);
        checkOutput("lu_bubble", {31'd0, idex_bubble}, 32'd1);
        checkOutput("lu_pcwrite", {31'd0, pc_write}, 32'd0);
        s.ex_rw = 5'd0; s.ex_regwr = 1'b0; s.ex_memtoreg = 1'b0;
        s.mem_rw = 5'd5; s.mem_regwr = 1'b1;
        applyStimulus(1'b1);
        checkOutput("lu_no_stall", {31'd0, idex_bubble}, 32'd0);
        checkOutput("lu_stall_cnt", {16'd0, stall_cnt}, 32'd1);
        s = '0;
        applyStimulus(1'b1);
        checkOutput("lu_fwd_a_memwb", {30'd0, fwd_a}, 32'd2);

        // add $3 in EX, sub $4,$3,$3 in ID, then same with destination $0
        s = '0; s.ex_rw = 5'd3; s.ex_regwr = 1'b1;
        s.id_rs = 5'd3; s.id_rt = 5'd3; s.id_uses_rt = 1'b1;
        applyStimulus(1'b1);
        s.ex_rw = 5'd0; s.id_rs = 5'd0; s.id_rt = 5'd0;
        applyStimulus(1'b1);
        checkOutput("ex_fwd_ab", {28'd0, fwd_a, fwd_b}, 32'h5);
        s = '0;
        applyStimulus(1'b1);
        checkOutput("r0_fwd_ab", {28'd0, fwd_a, fwd_b}, 32'h0);

        // Taken branch together with a load-use hazard
        do_reset();
        s.mem_branch = 1'b1; s.mem_zero = 1'b1;
        s.ex_rw = 5'd2; s.ex_regwr = 1'b1; s.ex_memtoreg = 1'b1; s.id_rs = 5'd2;
        applyStimulus(1'b1);
        checkOutput("br_pc_sel", {30'd0, pc_sel}, 32'd1);
        checkOutput("br_flushes", {29'd0, flush_ifid, flush_idex, flush_exmem}, 32'h7);
        checkOutput("br_no_bubble", {31'd0, idex_bubble}, 32'd0);
        s = '0;
        applyStimulus(1'b1);
        checkOutput("br_counts", {flush_cnt, stall_cnt}, 32'h0001_0000);

        // Jump plus taken branch, first frozen then released
        s.mem_jump = 1'b1; s.mem_branch = 1'b1; s.mem_zero = 1'b1; s.ext_stall = 1'b1;
        applyStimulus(1'b1);
        checkOutput("frz_pipe_en", {31'd0, pipe_en}, 32'd0);
        checkOutput("frz_flush", {31'd0, flush_ifid}, 32'd0);
        s.ext_stall = 1'b0;
        applyStimulus(1'b1);
        checkOutput("frz_cnt_held", {16'd0, flush_cnt}, 32'd1);
        checkOutput("jmp_pc_sel", {30'd0, pc_sel}, 32'd2);
        s = '0;
        applyStimulus(1'b1);
        checkOutput("jmp_flush_cnt", {16'd0, flush_cnt}, 32'd2);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            s.reset       = ($urandom_range(0, 63) == 0);
            s.id_rs       = 5'($urandom_range(0, 3));
            s.id_rt       = 5'($urandom_range(0, 3));
            s.id_uses_rt  = 1'($urandom_range(0, 1));
            s.ex_rw       = 5'($urandom_range(0, 3));
            s.ex_regwr    = ($urandom_range(0, 3) != 0);
            s.ex_memtoreg = ($urandom_range(0, 2) == 0);
            s.mem_rw      = 5'($urandom_range(0, 3));
            s.mem_regwr   = ($urandom_range(0, 3) != 0);
            s.mem_branch  = ($urandom_range(0, 4) == 0);
            s.mem_zero    = 1'($urandom_range(0, 1));
            s.mem_jump    = ($urandom_range(0, 9) == 0);
            s.ext_stall   = ($urandom_range(0, 5) == 0);
            applyStimulus(1'b1);
        end

        // Flush counter saturation
        do_reset();
        s.mem_jump = 1'b1;
        for (int i = 0; i < 65534; i++)
            applyStimulus(1'b0);
        applyStimulus(1'b1);
        checkOutput("sat_fffe", {16'd0, flush_cnt}, 32'hFFFE);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1);
            checkOutput("sat_ffff", {16'd0, flush_cnt}, 32'hFFFF);
        end
        s = '0;
        s.reset = 1'b1;
        applyStimulus(1'b1);
        s.reset = 1'b0;
        applyStimulus(1'b1);
        checkOutput("sat_reset", {16'd0, flush_cnt}, 32'd0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Clk  input  1  sole clock; all state updates on its rising edge.
REQ-002 Reset  input  1  synchronous, active-high reset, sampled on Clk rising edge.
REQ-003 ID_Rs, ID_Rt  input  5 each  source registers of the instruction in ID.
REQ-004 ID_UsesRt  input  1  ID instruction reads rt as a source (R-type, store, branch).
REQ-005 EX_Rw  input  5  destination of the instruction in EX; EX_RegWr  input  1  its write enable; EX_MemtoReg  input  1  EX instruction is a load.
REQ-006 MEM_Rw  input  5  destination in MEM; MEM_RegWr  input  1  its write enable.
REQ-007 MEM_Branch, MEM_Zero, MEM_Jump  input  1 each  branch/jump resolution from EX/MEM.
REQ-008 Ext_Stall  input  1  external freeze request (memory not ready).
REQ-009 Pipe_En  output  1  global stage-register enable; 0 freezes all stages.
REQ-010 PC_Write, IFID_Write  output  1 each  PC and IF/ID load enables.
REQ-011 IDEX_Bubble  output  1  load control zeros into ID/EX.
REQ-012 Flush_IFID, Flush_IDEX, Flush_EXMEM  output  1 each  squash stage contents.
REQ-013 PC_Sel  output  2  00 PC+4, 01 Btarg, 10 Jtarg, 11 unused.
REQ-014 FwdA, FwdB  output  2 each  registered EX operand selects: 00 register bus, 01 EX/MEM ALUout, 10 MEM/WB result.
REQ-015 Stall_Cnt, Flush_Cnt  output  16 each  saturating event counters.

Function
REQ-016 Redirect = (MEM_Branch & MEM_Zero) | MEM_Jump; PC_Sel = 10 when MEM_Jump, else 01 when taken branch, else 00; MEM_Jump wins if both.
REQ-017 On redirect with Ext_Stall=0: Flush_IFID=Flush_IDEX=Flush_EXMEM=1, PC_Write=1, same cycle (combinational).
REQ-018 Load-use = EX_MemtoReg & EX_RegWr & EX_Rw!=0 & (EX_Rw==ID_Rs | (ID_UsesRt & EX_Rw==ID_Rt)).
REQ-019 On load-use without redirect, Ext_Stall=0: PC_Write=0, IFID_Write=0, IDEX_Bubble=1 for exactly that cycle.
REQ-020 Priority: Ext_Stall > redirect > load-use; redirect suppresses load-use stall in the same cycle.
REQ-021 Ext_Stall=1: Pipe_En=0, PC_Write=IFID_Write=0, all flush/bubble outputs 0, PC_Sel=00, FwdA/FwdB and counters hold; redirect/load-use re-evaluated when released (inputs held by frozen pipeline).
REQ-022 Idle (no event, Ext_Stall=0): Pipe_En=PC_Write=IFID_Write=1, all flush/bubble 0, PC_Sel=00.
REQ-023 FwdA next (when Pipe_En=1, no bubble, no flush): 01 if EX_RegWr & EX_Rw!=0 & EX_Rw==ID_Rs; else 10 if MEM_RegWr & MEM_Rw!=0 & MEM_Rw==ID_Rs; else 00. FwdB identical using ID_Rt, forced 00 when ID_UsesRt=0.
REQ-024 FwdA/FwdB load 00 on any cycle with IDEX_Bubble=1 or Flush_IDEX=1; outputs valid for the instruction resident in EX.
REQ-025 Register 0 never forwarded; WB-to-ID hazard resolved by register file write-first, no forward code.
REQ-026 Stall_Cnt +1 per load-use bubble cycle; Flush_Cnt +1 per redirect cycle; both saturate at 16'hFFFF, no wrap.

Reset
REQ-027 Reset=1: FwdA=FwdB=00, Stall_Cnt=Flush_Cnt=0 on next edge; Reset dominates Ext_Stall and all events.
REQ-028 Combinational outputs follow REQ-016..022 during reset; reset mid-stall cancels no external state, counters restart at 0.

Verification
REQ-029 EX load to $5, ID add $6,$5,$7 -> 1 cycle PC_Write=0, IDEX_Bubble=1, Stall_Cnt=1; next cycle no stall, FwdA=10 in following cycle.
REQ-030 EX add $3, ID sub $4,$3,$3 -> next cycle FwdA=01, FwdB=01; same with EX_Rw=0 -> 00/00.
REQ-031 MEM_Branch=1, MEM_Zero=1 with simultaneous load-use -> PC_Sel=01, three flushes, no bubble, Flush_Cnt=1, Stall_Cnt=0.
REQ-032 MEM_Jump=1 and taken branch -> PC_Sel=10; Ext_Stall=1 same cycle -> no flush, Pipe_En=0, counters unchanged; release -> redirect takes effect.
REQ-033 Flush_Cnt preloaded to FFFE via 2 redirects after forcing, then 3 redirects -> holds FFFF; Reset -> 0.
